// File: rtl/inst_rom_loader_if.sv
// inst_rom_loader_if: program load stream and CPU fetch port of the instruction ROM loader
interface inst_rom_loader_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              load_start;
   logic              load_valid;
   logic [DATA_W-1:0] load_data;
   logic              load_last;
   logic              load_ready;
   logic              load_done;
   logic              load_err;
   logic [ADDR_W:0]   load_count;
   logic              cpu_hold;
   logic              rom_ce;
   logic [31:0]       rom_addr;
   logic [DATA_W-1:0] rom_data;
   modport master (
      output load_start, load_valid, load_data, load_last, rom_ce, rom_addr,
      input  load_ready, load_done, load_err, load_count, cpu_hold, rom_data
   );
   modport slave (
      input  load_start, load_valid, load_data, load_last, rom_ce, rom_addr,
      output load_ready, load_done, load_err, load_count, cpu_hold, rom_data
   );
endinterface

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: streams a program into word RAM, then serves zero-latency CPU fetches
module inst_rom_loader #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input logic               clk,
   input logic               rst,
   inst_rom_loader_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
   state_t            state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W:0]   count;
   logic              ready, done, err, hold;
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic              wr_en;
   logic [ADDR_W-1:0] idx;
   logic              hit;
   logic              unused_lsb;
   assign wr_en = bus.load_valid & ready;
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= bus.load_data;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         wr_ptr <= '0;
         count  <= '0;
         ready  <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         hold   <= 1'b1;
      end else if (state != LOAD) begin
         if (bus.load_start) begin
            state  <= LOAD;
            wr_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
            ready  <= 1'b1;
            done   <= 1'b0;
            hold   <= 1'b1;
         end
      end else if (wr_en) begin
         wr_ptr <= wr_ptr + 1'b1;
         count  <= count + 1'b1;
         // a full RAM without load_last ends the load as an overflow
         if (bus.load_last || wr_ptr == '1) begin
            state <= RUN;
            ready <= 1'b0;
            done  <= 1'b1;
            hold  <= 1'b0;
            err   <= !bus.load_last;
         end
      end
   end
   assign idx        = bus.rom_addr[ADDR_W+1:2];
   assign unused_lsb = ^bus.rom_addr[1:0];
   assign hit        = bus.rom_ce && state == RUN && bus.rom_addr[31:ADDR_W+2] == '0 && {1'b0, idx} < count;
   assign bus.rom_data   = hit ? mem[idx] : '0;
   assign bus.load_ready = ready;
   assign bus.load_done  = done;
   assign bus.load_err   = err;
   assign bus.load_count = count;
   assign bus.cpu_hold   = hold;
endmodule
